// File: rtl/dcache_data_bank.sv
// N-way data cache array: core word read/byte-masked write, line-fill and victim-evict engines.
// Latency: core read 1 cycle (dout registered); evict words start 2 cycles after ev_start.
// Backpressure: fill_ready drops only outside FILL; ev_valid/ev_data hold until ev_ready.
module dcache_data_bank #(
    parameter  int WAYS    = 4,
    parameter  int DW      = 32,
    parameter  int INDEX_W = 6,
    parameter  int WO_W    = 2,
    localparam int WAY_W   = $clog2(WAYS),
    localparam int BW      = DW / 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 we,
    input  logic [BW-1:0]        be,
    input  logic [INDEX_W-1:0]   index,
    input  logic [WAY_W-1:0]     way,
    input  logic [WO_W-1:0]      offset,
    input  logic [DW-1:0]        din,
    output logic [WAYS*DW-1:0]   dout,
    output logic                 rvalid,
    output logic                 busy,
    input  logic                 fill_start,
    input  logic [INDEX_W-1:0]   fill_index,
    input  logic [WAY_W-1:0]     fill_way,
    input  logic [DW-1:0]        fill_data,
    input  logic                 fill_valid,
    output logic                 fill_ready,
    output logic                 fill_done,
    input  logic                 ev_start,
    input  logic [INDEX_W-1:0]   ev_index,
    input  logic [WAY_W-1:0]     ev_way,
    output logic [DW-1:0]        ev_data,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic                 ev_done
);

    localparam int AW    = INDEX_W + WO_W;
    localparam int DEPTH = 1 << AW;
    localparam logic [WO_W-1:0] LAST_WORD = {WO_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        EVICT
    } state_t;

    state_t               state;
    logic [INDEX_W-1:0]   line_index;
    logic [WAY_W-1:0]     line_way;
    logic [WO_W-1:0]      cnt;
    logic                 ev_loaded;

    // One row per set/word holds every way, so a core read fetches all ways at once.
    logic [WAYS-1:0][DW-1:0] mem [DEPTH];

    logic [AW-1:0] core_addr;
    logic [AW-1:0] line_addr;
    logic          core_acc;
    logic          fill_hs;
    logic          ev_hs;
    logic          ev_load;

    assign core_addr = {index, offset};
    assign line_addr = {line_index, cnt};
    assign core_acc  = en && (state == IDLE);
    assign fill_hs   = (state == FILL) && fill_valid && fill_ready;
    assign ev_hs     = ev_valid && ev_ready;
    assign ev_load   = (state == EVICT) && !ev_loaded && (!ev_valid || ev_ready);

    // Array has no reset: contents survive rst_n, including a half-written fill line.
    always_ff @(posedge clk) begin
        if (rst_n && core_acc && we) begin
            for (int b = 0; b < BW; b++) begin
                if (be[b]) begin
                    mem[core_addr][way][b*8 +: 8] <= din[b*8 +: 8];
                end
            end
        end
        if (rst_n && fill_hs) begin
            mem[line_addr][line_way] <= fill_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            line_index <= '0;
            line_way   <= '0;
            cnt        <= '0;
            ev_loaded  <= 1'b0;
            dout       <= '0;
            rvalid     <= 1'b0;
            busy       <= 1'b0;
            fill_ready <= 1'b0;
            fill_done  <= 1'b0;
            ev_valid   <= 1'b0;
            ev_data    <= '0;
            ev_done    <= 1'b0;
        end else begin
            rvalid    <= 1'b0;
            fill_done <= 1'b0;
            ev_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (core_acc) begin
                        dout   <= mem[core_addr];
                        rvalid <= ~we;
                    end
                    if (ev_start) begin
                        state      <= EVICT;
                        line_index <= ev_index;
                        line_way   <= ev_way;
                        cnt        <= '0;
                        ev_loaded  <= 1'b0;
                        busy       <= 1'b1;
                    end else if (fill_start) begin
                        state      <= FILL;
                        line_index <= fill_index;
                        line_way   <= fill_way;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        fill_ready <= 1'b1;
                    end
                end
                FILL: begin
                    if (fill_hs) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_WORD) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            fill_ready <= 1'b0;
                            fill_done  <= 1'b1;
                        end
                    end
                end
                EVICT: begin
                    // ev_loaded means the output register holds the final word.
                    if (ev_hs && ev_loaded) begin
                        ev_valid <= 1'b0;
                        ev_done  <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (ev_load) begin
                        ev_data  <= mem[line_addr][line_way];
                        ev_valid <= 1'b1;
                        cnt      <= cnt + 1'b1;
                        if (cnt == LAST_WORD) begin
                            ev_loaded <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
